// File: rtl/cu_pkg.sv
// Shared opcodes, FSM states, instruction classes and the control-word layout for the Mini SRC control unit.
package cu_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_ADD = 5'b00011;

  // E0..E5 must stay consecutive: the sequencer steps through them by increment.
  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3,
    S_E0, S_E1, S_E2, S_E3, S_E4, S_E5,
    S_MW, S_HALT
  } state_t;

  typedef enum logic [4:0] {
    CL_ALU, CL_ALU_UN, CL_IMM, CL_LDI, CL_LD, CL_ST, CL_MULDIV,
    CL_BR, CL_JR, CL_JAL, CL_IN, CL_OUT, CL_MFHI, CL_MFLO,
    CL_NOP, CL_HALT, CL_UNDEF
  } op_class_t;

  typedef struct packed {
    logic [4:0] control;
    logic read, write, inc_pc, clear_dp;
    logic pc_out, mdr_out, zhi_out, zlo_out, hi_out, lo_out;
    logic c_out, inport_out, ba_out, r_out;
    logic pc_in, mdr_in, mar_in, ir_in, y_in, zhi_in, zlo_in;
    logic hi_in, lo_in, outport_in, conff_in, r_in;
    logic g_ra, g_rb, g_rc;
  } ctrl_t;

endpackage

// File: rtl/cu_op_class.sv
// Combinational opcode decode: instruction class and the final execute step of that class.
module cu_op_class
  import cu_pkg::*;
(
  input  logic [4:0] op,
  output op_class_t  op_class,
  output state_t     last_step
);

  always_comb begin
    op_class  = CL_UNDEF;
    last_step = S_E0;
    case (op)
      OP_LD:   begin op_class = CL_LD;  last_step = S_E5; end
      OP_LDI:  begin op_class = CL_LDI; last_step = S_E2; end
      OP_ST:   begin op_class = CL_ST;  last_step = S_E4; end
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL:
               begin op_class = CL_ALU; last_step = S_E2; end
      OP_ADDI, OP_ANDI, OP_ORI:
               begin op_class = CL_IMM; last_step = S_E2; end
      OP_MUL, OP_DIV:
               begin op_class = CL_MULDIV; last_step = S_E3; end
      OP_NEG, OP_NOT:
               begin op_class = CL_ALU_UN; last_step = S_E2; end
      OP_BR:   begin op_class = CL_BR;   last_step = S_E3; end
      OP_JR:   begin op_class = CL_JR;   last_step = S_E0; end
      OP_JAL:  begin op_class = CL_JAL;  last_step = S_E1; end
      OP_IN:   begin op_class = CL_IN;   last_step = S_E0; end
      OP_OUT:  begin op_class = CL_OUT;  last_step = S_E0; end
      OP_MFHI: begin op_class = CL_MFHI; last_step = S_E0; end
      OP_MFLO: begin op_class = CL_MFLO; last_step = S_E0; end
      OP_NOP:  op_class = CL_NOP;
      OP_HALT: op_class = CL_HALT;
      default: op_class = CL_UNDEF;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Mini SRC control sequencer with registered Moore control strobes.
// Define CU_ILLEGAL_HALT_EN to halt on undefined opcodes and expose the sticky Illegal flag.
module control_unit #(
  parameter int unsigned MULDIV_WAIT = 2,
  parameter logic [4:0]  ALU_ADD     = cu_pkg::ALU_ADD
) (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR_Data,
  input  logic        ConFF_Out,
  input  logic        Stop,
  output logic        Run,
`ifdef CU_ILLEGAL_HALT_EN
  output logic        Illegal,
`endif
  output logic [4:0]  CONTROL,
  output logic        Read, Write, IncPC, Clear_DP,
  output logic        PC_Out, MDR_Out, ZHI_Out, ZLO_Out, HI_Out, LO_Out,
  output logic        C_Out, InPort_Out, BA_Out, R_Out,
  output logic        PC_In, MDR_In, MAR_In, IR_In, Y_In, ZHI_In, ZLO_In,
  output logic        HI_In, LO_In, OutPort_In, ConFF_In, R_In,
  output logic        G_RA, G_RB, G_RC
);
  import cu_pkg::*;

  state_t     state, ns, last_step;
  op_class_t  cls;
  logic [4:0] op_q, op_cur;
  logic [2:0] wait_cnt, wait_nxt;
  ctrl_t      ctrl_q, ctrl_d;
  logic       run_q;
  logic       unused_ir;
`ifdef CU_ILLEGAL_HALT_EN
  logic       illegal_q, illegal_set;
`endif

  assign unused_ir = ^IR_Data[26:0];

  // In T3 the opcode is taken straight from IR so the class is known before E0 latches it.
  assign op_cur = (state == S_T3) ? IR_Data[31:27] : op_q;

  cu_op_class u_op_class (
    .op        (op_cur),
    .op_class  (cls),
    .last_step (last_step)
  );

  always_comb begin
    ns       = state;
    wait_nxt = wait_cnt;
`ifdef CU_ILLEGAL_HALT_EN
    illegal_set = 1'b0;
`endif
    case (state)
      S_RST:  ns = S_T0;
      S_T0:   ns = Stop ? S_HALT : S_T1;
      S_T1:   ns = S_T2;
      S_T2:   ns = S_T3;
      S_T3: begin
        case (cls)
          CL_NOP:   ns = S_T0;
          CL_HALT:  ns = S_HALT;
          CL_UNDEF: begin
`ifdef CU_ILLEGAL_HALT_EN
            ns          = S_HALT;
            illegal_set = 1'b1;
`else
            ns = S_T0;
`endif
          end
          default:  ns = S_E0;
        endcase
      end
      S_MW: begin
        if (wait_cnt == '0) ns = S_E1;
        else                wait_nxt = wait_cnt - 3'd1;
      end
      S_HALT: ns = S_HALT;
      default: begin
        if (state == last_step) begin
          ns = S_T0;
        end else if (state == S_E0 && cls == CL_MULDIV && MULDIV_WAIT != 0) begin
          ns       = S_MW;
          wait_nxt = 3'(MULDIV_WAIT - 1);
        end else begin
          ns = state_t'(state + 4'd1);
        end
      end
    endcase
  end

  // Strobes are decoded from the state being entered so they register in step with it.
  always_comb begin
    ctrl_d = '0;
    case (ns)
      S_T0: begin ctrl_d.pc_out = 1'b1; ctrl_d.mar_in = 1'b1; ctrl_d.inc_pc = 1'b1; end
      S_T1: ctrl_d.read = 1'b1;
      S_T2: begin ctrl_d.read = 1'b1; ctrl_d.mdr_in = 1'b1; end
      S_T3: begin ctrl_d.mdr_out = 1'b1; ctrl_d.ir_in = 1'b1; end
      S_E0: begin
        case (cls)
          CL_ALU, CL_ALU_UN, CL_IMM, CL_LDI, CL_LD, CL_ST: begin
            ctrl_d.g_rb = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.y_in = 1'b1;
            ctrl_d.ba_out = (cls == CL_LDI || cls == CL_LD || cls == CL_ST);
          end
          CL_MULDIV: begin ctrl_d.g_ra = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.y_in = 1'b1; end
          CL_BR:     begin ctrl_d.g_ra = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.conff_in = 1'b1; end
          CL_JR:     begin ctrl_d.g_ra = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.pc_in = 1'b1; end
          CL_JAL:    begin ctrl_d.pc_out = 1'b1; ctrl_d.g_rb = 1'b1; ctrl_d.r_in = 1'b1; end
          CL_IN:     begin ctrl_d.inport_out = 1'b1; ctrl_d.g_ra = 1'b1; ctrl_d.r_in = 1'b1; end
          CL_OUT:    begin ctrl_d.g_ra = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.outport_in = 1'b1; end
          CL_MFHI:   begin ctrl_d.hi_out = 1'b1; ctrl_d.g_ra = 1'b1; ctrl_d.r_in = 1'b1; end
          CL_MFLO:   begin ctrl_d.lo_out = 1'b1; ctrl_d.g_ra = 1'b1; ctrl_d.r_in = 1'b1; end
          default: ;
        endcase
      end
      S_E1: begin
        case (cls)
          CL_ALU, CL_ALU_UN: begin
            ctrl_d.g_rc = (cls == CL_ALU); ctrl_d.g_rb = (cls == CL_ALU_UN);
            ctrl_d.r_out = 1'b1; ctrl_d.control = op_cur; ctrl_d.zlo_in = 1'b1;
          end
          CL_IMM: begin ctrl_d.c_out = 1'b1; ctrl_d.control = op_cur; ctrl_d.zlo_in = 1'b1; end
          CL_LDI, CL_LD, CL_ST: begin
            ctrl_d.c_out = 1'b1; ctrl_d.control = ALU_ADD; ctrl_d.zlo_in = 1'b1;
          end
          CL_MULDIV: begin
            ctrl_d.control = op_cur; ctrl_d.zhi_in = 1'b1; ctrl_d.zlo_in = 1'b1;
          end
          CL_BR:  begin ctrl_d.pc_out = 1'b1; ctrl_d.y_in = 1'b1; end
          CL_JAL: begin ctrl_d.g_ra = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.pc_in = 1'b1; end
          default: ;
        endcase
      end
      S_E2: begin
        case (cls)
          CL_ALU, CL_ALU_UN, CL_IMM, CL_LDI: begin
            ctrl_d.zlo_out = 1'b1; ctrl_d.g_ra = 1'b1; ctrl_d.r_in = 1'b1;
          end
          CL_LD, CL_ST: begin ctrl_d.zlo_out = 1'b1; ctrl_d.mar_in = 1'b1; end
          CL_MULDIV:    begin ctrl_d.zlo_out = 1'b1; ctrl_d.lo_in = 1'b1; end
          CL_BR: begin ctrl_d.c_out = 1'b1; ctrl_d.control = ALU_ADD; ctrl_d.zlo_in = 1'b1; end
          default: ;
        endcase
      end
      S_E3: begin
        case (cls)
          CL_LD:     ctrl_d.read = 1'b1;
          CL_ST:     begin ctrl_d.g_ra = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.mdr_in = 1'b1; end
          CL_MULDIV: begin ctrl_d.zhi_out = 1'b1; ctrl_d.hi_in = 1'b1; end
          CL_BR:     begin ctrl_d.zlo_out = ConFF_Out; ctrl_d.pc_in = ConFF_Out; end
          default: ;
        endcase
      end
      S_E4: begin
        if (cls == CL_LD) begin ctrl_d.read = 1'b1; ctrl_d.mdr_in = 1'b1; end
        if (cls == CL_ST) ctrl_d.write = 1'b1;
      end
      S_E5: begin
        if (cls == CL_LD) begin ctrl_d.mdr_out = 1'b1; ctrl_d.g_ra = 1'b1; ctrl_d.r_in = 1'b1; end
      end
      S_MW: ctrl_d.control = op_cur;
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Clear) begin
      state           <= S_RST;
      ctrl_q          <= '0;
      ctrl_q.clear_dp <= 1'b1;
      run_q           <= 1'b0;
      wait_cnt        <= '0;
`ifdef CU_ILLEGAL_HALT_EN
      illegal_q       <= 1'b0;
`endif
    end else begin
      state    <= ns;
      ctrl_q   <= ctrl_d;
      run_q    <= (ns != S_HALT);
      wait_cnt <= wait_nxt;
      if (state == S_T3 && ns == S_E0) op_q <= IR_Data[31:27];
`ifdef CU_ILLEGAL_HALT_EN
      if (illegal_set) illegal_q <= 1'b1;
`endif
    end
  end

`ifdef CU_ILLEGAL_HALT_EN
  assign Illegal = illegal_q;
`endif
  assign Run        = run_q;
  assign CONTROL    = ctrl_q.control;
  assign Read       = ctrl_q.read;
  assign Write      = ctrl_q.write;
  assign IncPC      = ctrl_q.inc_pc;
  assign Clear_DP   = ctrl_q.clear_dp;
  assign PC_Out     = ctrl_q.pc_out;
  assign MDR_Out    = ctrl_q.mdr_out;
  assign ZHI_Out    = ctrl_q.zhi_out;
  assign ZLO_Out    = ctrl_q.zlo_out;
  assign HI_Out     = ctrl_q.hi_out;
  assign LO_Out     = ctrl_q.lo_out;
  assign C_Out      = ctrl_q.c_out;
  assign InPort_Out = ctrl_q.inport_out;
  assign BA_Out     = ctrl_q.ba_out;
  assign R_Out      = ctrl_q.r_out;
  assign PC_In      = ctrl_q.pc_in;
  assign MDR_In     = ctrl_q.mdr_in;
  assign MAR_In     = ctrl_q.mar_in;
  assign IR_In      = ctrl_q.ir_in;
  assign Y_In       = ctrl_q.y_in;
  assign ZHI_In     = ctrl_q.zhi_in;
  assign ZLO_In     = ctrl_q.zlo_in;
  assign HI_In      = ctrl_q.hi_in;
  assign LO_In      = ctrl_q.lo_in;
  assign OutPort_In = ctrl_q.outport_in;
  assign ConFF_In   = ctrl_q.conff_in;
  assign R_In       = ctrl_q.r_in;
  assign G_RA       = ctrl_q.g_ra;
  assign G_RB       = ctrl_q.g_rb;
  assign G_RC       = ctrl_q.g_rc;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: a per-instruction step-table model queues expected
// control words; a negedge monitor pops and compares one word per cycle.
module tb_control_unit;

  localparam int unsigned MW_CYC = 2;
  typedef logic [35:0] word_t;

  // Word layout: [0..28] single strobes, [33:29] CONTROL, [34] Run, [35] Illegal.
  localparam word_t RD   = 36'h1 << 0,  WR   = 36'h1 << 1,  INC  = 36'h1 << 2,  CDP  = 36'h1 << 3;
  localparam word_t PCO  = 36'h1 << 4,  MDRO = 36'h1 << 5,  ZHO  = 36'h1 << 6,  ZLO  = 36'h1 << 7;
  localparam word_t HIO  = 36'h1 << 8,  LOO  = 36'h1 << 9,  CO   = 36'h1 << 10, INPO = 36'h1 << 11;
  localparam word_t BAO  = 36'h1 << 12, RO   = 36'h1 << 13, PCI  = 36'h1 << 14, MDRI = 36'h1 << 15;
  localparam word_t MARI = 36'h1 << 16, IRI  = 36'h1 << 17, YI   = 36'h1 << 18, ZHI  = 36'h1 << 19;
  localparam word_t ZLI  = 36'h1 << 20, HII  = 36'h1 << 21, LOI  = 36'h1 << 22, OUTI = 36'h1 << 23;
  localparam word_t CFI  = 36'h1 << 24, RI   = 36'h1 << 25, GRA  = 36'h1 << 26, GRB  = 36'h1 << 27;
  localparam word_t GRC  = 36'h1 << 28, RUN  = 36'h1 << 34, ILL  = 36'h1 << 35;

  logic clk = 1'b0;
  logic Clear = 1'b0, ConFF_Out = 1'b0, Stop = 1'b0;
  logic [31:0] IR_Data = '0;
  logic Run, Read, Write, IncPC, Clear_DP;
  logic [4:0] CONTROL;
  logic PC_Out, MDR_Out, ZHI_Out, ZLO_Out, HI_Out, LO_Out, C_Out, InPort_Out, BA_Out, R_Out;
  logic PC_In, MDR_In, MAR_In, IR_In, Y_In, ZHI_In, ZLO_In, HI_In, LO_In, OutPort_In, ConFF_In, R_In;
  logic G_RA, G_RB, G_RC;
  logic ill_obs;
`ifdef CU_ILLEGAL_HALT_EN
  logic Illegal;
  assign ill_obs = Illegal;
`else
  assign ill_obs = 1'b0;
`endif

  control_unit #(.MULDIV_WAIT(MW_CYC), .ALU_ADD(5'b00011)) dut (
    .Clock(clk), .Clear(Clear), .IR_Data(IR_Data), .ConFF_Out(ConFF_Out), .Stop(Stop),
    .Run(Run),
`ifdef CU_ILLEGAL_HALT_EN
    .Illegal(Illegal),
`endif
    .CONTROL(CONTROL), .Read(Read), .Write(Write), .IncPC(IncPC), .Clear_DP(Clear_DP),
    .PC_Out(PC_Out), .MDR_Out(MDR_Out), .ZHI_Out(ZHI_Out), .ZLO_Out(ZLO_Out),
    .HI_Out(HI_Out), .LO_Out(LO_Out), .C_Out(C_Out), .InPort_Out(InPort_Out),
    .BA_Out(BA_Out), .R_Out(R_Out), .PC_In(PC_In), .MDR_In(MDR_In), .MAR_In(MAR_In),
    .IR_In(IR_In), .Y_In(Y_In), .ZHI_In(ZHI_In), .ZLO_In(ZLO_In), .HI_In(HI_In),
    .LO_In(LO_In), .OutPort_In(OutPort_In), .ConFF_In(ConFF_In), .R_In(R_In),
    .G_RA(G_RA), .G_RB(G_RB), .G_RC(G_RC)
  );

  always #5 clk = ~clk;

  word_t obs;
  assign obs = {ill_obs, Run, CONTROL, G_RC, G_RB, G_RA, R_In, ConFF_In, OutPort_In, LO_In,
                HI_In, ZLO_In, ZHI_In, Y_In, IR_In, MAR_In, MDR_In, PC_In, R_Out, BA_Out,
                InPort_Out, C_Out, LO_Out, HI_Out, ZLO_Out, ZHI_Out, MDR_Out, PC_Out,
                Clear_DP, IncPC, Write, Read};

  word_t sb_w[$];
  string sb_t[$];
  int    n_chk = 0, n_fail = 0;
  word_t m_exp;
  string m_tag;

  always @(negedge clk) begin
    if (sb_w.size() != 0) begin
      m_exp = sb_w.pop_front();
      m_tag = sb_t.pop_front();
      n_chk++;
      if (obs !== m_exp) begin
        n_fail++;
        $display("FAIL %s got=%h exp=%h", m_tag, obs, m_exp);
      end
    end
  end

  function automatic word_t ctl(input logic [4:0] c);
    return word_t'(c) << 29;
  endfunction

  task automatic push(input word_t w, input string tag);
    sb_w.push_back(w);
    sb_t.push_back(tag);
  endtask

  // Reference model: fetch plus the execute step table of the instruction, straight from the ISA rules.
  task automatic issue(input logic [31:0] ir, input logic cf, input logic stp,
                       input int keep, input int halt_words);
    word_t w[$];
    int o;
    o = int'(ir[31:27]);
    IR_Data = ir; ConFF_Out = cf; Stop = stp;
    w.push_back(RUN | PCO | MARI | INC);
    if (stp) begin
      repeat (halt_words) w.push_back('0);
    end else begin
      w.push_back(RUN | RD);
      w.push_back(RUN | RD | MDRI);
      w.push_back(RUN | MDRO | IRI);
      if (o >= 3 && o <= 11) begin
        w.push_back(RUN | GRB | RO | YI);
        w.push_back(RUN | GRC | RO | ctl(ir[31:27]) | ZLI);
        w.push_back(RUN | ZLO | GRA | RI);
      end else if (o == 17 || o == 18) begin
        w.push_back(RUN | GRB | RO | YI);
        w.push_back(RUN | GRB | RO | ctl(ir[31:27]) | ZLI);
        w.push_back(RUN | ZLO | GRA | RI);
      end else if (o >= 12 && o <= 14) begin
        w.push_back(RUN | GRB | RO | YI);
        w.push_back(RUN | CO | ctl(ir[31:27]) | ZLI);
        w.push_back(RUN | ZLO | GRA | RI);
      end else if (o <= 2) begin
        w.push_back(RUN | GRB | RO | BAO | YI);
        w.push_back(RUN | CO | ctl(5'b00011) | ZLI);
        if (o == 1) w.push_back(RUN | ZLO | GRA | RI);
        else        w.push_back(RUN | ZLO | MARI);
        if (o == 0) begin
          w.push_back(RUN | RD);
          w.push_back(RUN | RD | MDRI);
          w.push_back(RUN | MDRO | GRA | RI);
        end else if (o == 2) begin
          w.push_back(RUN | GRA | RO | MDRI);
          w.push_back(RUN | WR);
        end
      end else if (o == 15 || o == 16) begin
        w.push_back(RUN | GRA | RO | YI);
        repeat (MW_CYC) w.push_back(RUN | ctl(ir[31:27]));
        w.push_back(RUN | ctl(ir[31:27]) | ZHI | ZLI);
        w.push_back(RUN | ZLO | LOI);
        w.push_back(RUN | ZHO | HII);
      end else if (o == 19) begin
        w.push_back(RUN | GRA | RO | CFI);
        w.push_back(RUN | PCO | YI);
        w.push_back(RUN | CO | ctl(5'b00011) | ZLI);
        w.push_back(cf ? (RUN | ZLO | PCI) : RUN);
      end else if (o == 20) w.push_back(RUN | GRA | RO | PCI);
      else if (o == 21) begin
        w.push_back(RUN | PCO | GRB | RI);
        w.push_back(RUN | GRA | RO | PCI);
      end
      else if (o == 22) w.push_back(RUN | INPO | GRA | RI);
      else if (o == 23) w.push_back(RUN | GRA | RO | OUTI);
      else if (o == 24) w.push_back(RUN | HIO | GRA | RI);
      else if (o == 25) w.push_back(RUN | LOO | GRA | RI);
      else if (o == 27) repeat (halt_words) w.push_back('0);
`ifdef CU_ILLEGAL_HALT_EN
      else if (o >= 28) repeat (halt_words) w.push_back(ILL);
`endif
    end
    for (int i = 0; i < w.size(); i++)
      if (keep < 0 || i < keep) push(w[i], $sformatf("op%0d_cf%0d_step%0d", o, cf, i));
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (sb_w.size() != 0 && n < 200);
    if (sb_w.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL idle_timeout pending=%0d required=0", sb_w.size());
      sb_w.delete(); sb_t.delete();
    end
  endtask

  task automatic do_reset(input int cycles);
    Clear = 1'b0;
    repeat (cycles) begin
      @(posedge clk); #1;
      push(CDP, "reset");
    end
    Clear = 1'b1;
  endtask

  task automatic run_instr(input logic [31:0] ir, input logic cf);
    issue(ir, cf, 1'b0, -1, 0);
    wait_idle();
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op);
    logic [26:0] r;
    r = 27'($urandom);
    return {op, r};
  endfunction

  initial begin
    logic [4:0] op;
    do_reset(3);
    wait_idle();

    run_instr(32'h1A918000, 1'b0);
    run_instr(mk(5'b00010), 1'b0);
    run_instr(mk(5'b10011), 1'b0);
    run_instr(mk(5'b10011), 1'b1);
    run_instr(mk(5'b01111), 1'b0);
    for (int k = 0; k <= 26; k++) begin
      op = 5'(k);
      run_instr(mk(op), 1'($urandom));
    end
`ifndef CU_ILLEGAL_HALT_EN
    run_instr(mk(5'b11111), 1'b0);
    run_instr(mk(5'b11100), 1'b1);
`endif

    for (int k = 0; k < 80; k++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'b11011) op = 5'b11010;
`ifdef CU_ILLEGAL_HALT_EN
      if (op >= 5'b11100) op = 5'b11010;
`endif
      run_instr(mk(op), 1'($urandom));
    end

    // Abort a load at E3: E3 still shows Read, then reset, then a clean fetch.
    issue(mk(5'b00000), 1'b0, 1'b0, 7, 0);
    wait_idle();
    push(RUN | RD, "ld_abort_e3");
    do_reset(1);
    wait_idle();
    run_instr(mk(5'b00011), 1'b0);

    // Stop request in T0.
    issue(mk(5'b00011), 1'b0, 1'b1, -1, 3);
    wait_idle();
    Stop = 1'b0;
    do_reset(2);
    wait_idle();

    // halt opcode.
    issue(mk(5'b11011), 1'b0, 1'b0, -1, 3);
    wait_idle();
    do_reset(2);
    wait_idle();

`ifdef CU_ILLEGAL_HALT_EN
    issue(mk(5'b11111), 1'b0, 1'b0, -1, 3);
    wait_idle();
    do_reset(2);
    wait_idle();
`endif
    run_instr(mk(5'b10101), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

endmodule
